// File: rtl/lt_pkg.sv
// Shared constants and types for the piecewise-linear transform table loader.
package lt_pkg;

    localparam int NSEG          = 16;
    localparam int WORDS_PER_SEG = 3;
    localparam int NWORDS        = NSEG * WORDS_PER_SEG;
    localparam int SEG_W         = $clog2(NSEG);

    typedef enum logic [1:0] {
        FLD_M = 2'd0,
        FLD_C = 2'd1,
        FLD_D = 2'd2
    } fld_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CHECK   = 2'd2,
        PENDING = 2'd3
    } state_t;

    // True for the delta word of the last segment, i.e. word NWORDS-1.
    function automatic logic is_last_word(input logic [SEG_W-1:0] seg, input fld_t fld);
        return (seg == SEG_W'(NSEG - 1)) && (fld == FLD_D);
    endfunction

endpackage

// File: rtl/lt_coef_bank.sv
// Shadow and active coefficient register arrays (M, C, delta) with per-word
// write into the shadow bank and a one-cycle bulk shadow-to-active copy.
module lt_coef_bank
    import lt_pkg::*;
#(
    parameter int DSIZE = 12,
    parameter int DTW   = 12,
    parameter int WSIZE = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [SEG_W-1:0]      wr_seg,
    input  logic [1:0]            wr_fld,
    input  logic [WSIZE-1:0]      wr_data,
    input  logic                  copy,
    input  logic [SEG_W-1:0]      rd_seg,
    output logic [DSIZE-1:0]      rd_m_lo,
    output logic [DSIZE-1:0]      rd_m_hi,
    output logic [NSEG*DSIZE-1:0] m_flat,
    output logic [NSEG*DSIZE-1:0] c_flat,
    output logic [NSEG*DTW-1:0]   delta_flat
);

    logic [DSIZE-1:0] m_sh  [NSEG];
    logic [DSIZE-1:0] c_sh  [NSEG];
    logic [DTW-1:0]   d_sh  [NSEG];
    logic [DSIZE-1:0] m_act [NSEG];
    logic [DSIZE-1:0] c_act [NSEG];
    logic [DTW-1:0]   d_act [NSEG];

    logic [SEG_W-1:0] rd_seg_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NSEG; i++) begin
                m_sh[i] <= '0;
                c_sh[i] <= '0;
                d_sh[i] <= '0;
            end
        end else if (wr_en) begin
            case (wr_fld)
                FLD_M:   m_sh[wr_seg] <= wr_data[DSIZE-1:0];
                FLD_C:   c_sh[wr_seg] <= wr_data[DSIZE-1:0];
                default: d_sh[wr_seg] <= wr_data[DTW-1:0];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NSEG; i++) begin
                m_act[i] <= '0;
                c_act[i] <= '0;
                d_act[i] <= '0;
            end
        end else if (copy) begin
            for (int i = 0; i < NSEG; i++) begin
                m_act[i] <= m_sh[i];
                c_act[i] <= c_sh[i];
                d_act[i] <= d_sh[i];
            end
        end
    end

    // Adjacent shadow breakpoints for the order check.
    assign rd_seg_nxt = rd_seg + 1'b1;
    assign rd_m_lo    = m_sh[rd_seg];
    assign rd_m_hi    = m_sh[rd_seg_nxt];

    for (genvar k = 0; k < NSEG; k++) begin : g_flat
        assign m_flat[k*DSIZE +: DSIZE]   = m_act[k];
        assign c_flat[k*DSIZE +: DSIZE]   = c_act[k];
        assign delta_flat[k*DTW +: DTW]   = d_act[k];
    end

endmodule

// File: rtl/linear_transform_table_loader.sv
// Loads a 48-word M/C/delta coefficient stream into a shadow bank, checks
// breakpoint monotonicity, and swaps it into the active bank at frame_start.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a word with s_sof; other words are dropped
// LOAD    | filling the shadow bank, word index = seg_cnt*3 + fld_cnt
// CHECK   | one breakpoint compare M_k <= M_{k+1} per cycle, k = 0..14
// PENDING | checked table waiting for frame_start to swap
module linear_transform_table_loader
    import lt_pkg::*;
#(
    parameter int DSIZE = 12,
    parameter int DT_I  = 8,
    parameter int DT_D  = 4,
    parameter int WSIZE = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WSIZE-1:0]              s_data,
    input  logic                          s_sof,
    input  logic                          frame_start,
    output logic [NSEG*DSIZE-1:0]         m_flat,
    output logic [NSEG*DSIZE-1:0]         c_flat,
    output logic [NSEG*(DT_I+DT_D)-1:0]   delta_flat,
    output logic                          table_valid,
    output logic                          busy,
    output logic                          swap_done,
    output logic                          err_order,
    output logic                          err_seq
);

    localparam int DTW = DT_I + DT_D;

    state_t           state;
    state_t           state_nxt;
    logic [SEG_W-1:0] seg_cnt;
    fld_t             fld_cnt;
    logic [SEG_W-1:0] chk_k;

    logic             xfer;
    logic             wr_en;
    logic [SEG_W-1:0] wr_seg;
    fld_t             wr_fld;
    logic             copy;
    logic             chk_ok;
    logic             err_seq_nxt;
    logic             err_order_nxt;
    logic [DSIZE-1:0] rd_m_lo;
    logic [DSIZE-1:0] rd_m_hi;

    assign xfer   = s_valid && s_ready;
    assign chk_ok = (rd_m_lo <= rd_m_hi);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer && s_sof) state_nxt = LOAD;
            end
            LOAD: begin
                if (xfer && !s_sof && is_last_word(seg_cnt, fld_cnt)) state_nxt = CHECK;
            end
            CHECK: begin
                if (!chk_ok)                              state_nxt = IDLE;
                else if (chk_k == SEG_W'(NSEG - 2))       state_nxt = PENDING;
            end
            PENDING: begin
                if (frame_start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready       = (state == IDLE) || (state == LOAD);
        busy          = (state != IDLE);
        wr_en         = xfer && (s_sof || (state == LOAD));
        wr_seg        = s_sof ? '0 : seg_cnt;
        wr_fld        = s_sof ? FLD_M : fld_cnt;
        copy          = (state == PENDING) && frame_start;
        err_seq_nxt   = (state == LOAD) && xfer && s_sof;
        err_order_nxt = (state == CHECK) && !chk_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_cnt     <= '0;
            fld_cnt     <= FLD_M;
            chk_k       <= '0;
            err_seq     <= 1'b0;
            err_order   <= 1'b0;
            swap_done   <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            err_seq   <= err_seq_nxt;
            err_order <= err_order_nxt;
            swap_done <= copy;
            if (copy) table_valid <= 1'b1;

            // A start-of-table word is always word 0, so the next index is 1.
            if (wr_en) begin
                if (s_sof) begin
                    seg_cnt <= '0;
                    fld_cnt <= FLD_C;
                end else begin
                    case (fld_cnt)
                        FLD_M:   fld_cnt <= FLD_C;
                        FLD_C:   fld_cnt <= FLD_D;
                        default: begin
                            fld_cnt <= FLD_M;
                            seg_cnt <= seg_cnt + 1'b1;
                        end
                    endcase
                end
            end

            if (state == CHECK) chk_k <= chk_k + 1'b1;
            else                chk_k <= '0;
        end
    end

    lt_coef_bank #(
        .DSIZE (DSIZE),
        .DTW   (DTW),
        .WSIZE (WSIZE)
    ) u_bank (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_seg     (wr_seg),
        .wr_fld     (wr_fld),
        .wr_data    (s_data),
        .copy       (copy),
        .rd_seg     (chk_k),
        .rd_m_lo    (rd_m_lo),
        .rd_m_hi    (rd_m_hi),
        .m_flat     (m_flat),
        .c_flat     (c_flat),
        .delta_flat (delta_flat)
    );

endmodule
